// File: rtl/csr_unit.sv
// Machine-mode CSR file and single-cycle trap sequencer.
// Holds the architectural M-mode CSRs, serves combinational reads to the
// execute unit, and issues a registered one-cycle redirect on exceptions.
module csr_unit #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned HARTID = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_valid,
    input  logic [XLEN-1:0] io_pc,
    input  logic [11:0]     io_csr_raddr,
    output logic [XLEN-1:0] io_csr_rdata,
    output logic            io_csr_illegal,
    input  logic            io_csr_is_w,
    input  logic [11:0]     io_csr_waddr,
    input  logic [XLEN-1:0] io_csr_wdata,
    input  logic            io_is_except,
    input  logic [5:0]      io_exception,
    output logic [XLEN-1:0] io_mepc,
    output logic [XLEN-1:0] io_mstatus,
    output logic            io_trap_valid,
    output logic [XLEN-1:0] io_trap_pc,
    output logic            io_busy
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    typedef enum logic {
        IDLE,
        TRAP
    } state_e;

    state_e          state_q, state_d;
    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mcycle_q, mcycle_d;
    logic [XLEN-1:0] minstret_q, minstret_d;
    logic [XLEN-1:0] trap_pc_q, trap_pc_d;

    logic            take_trap;
    logic            do_write;
    logic [XLEN-1:0] mstatus_rd;

    // Assemble the visible mstatus image: MPP fixed to M-mode, only MIE/MPIE live.
    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = mpie_q;
        mstatus_rd[3]     = mie_q;
    end

    // Combinational CSR read port (pre-update values, no write bypass).
    always_comb begin
        io_csr_rdata   = '0;
        io_csr_illegal = 1'b0;
        case (io_csr_raddr)
            A_MSTATUS:  io_csr_rdata = mstatus_rd;
            A_MTVEC:    io_csr_rdata = mtvec_q;
            A_MSCRATCH: io_csr_rdata = mscratch_q;
            A_MEPC:     io_csr_rdata = mepc_q;
            A_MCAUSE:   io_csr_rdata = mcause_q;
            A_MCYCLE:   io_csr_rdata = mcycle_q;
            A_MINSTRET: io_csr_rdata = minstret_q;
            A_MHARTID:  io_csr_rdata = XLEN'(HARTID);
            default:    io_csr_illegal = 1'b1;
        endcase
    end

    // Next-state logic: trap entry has priority over CSR writes; TRAP ignores all inputs.
    always_comb begin
        state_d    = state_q;
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mcycle_d   = mcycle_q + XLEN'(1);
        minstret_d = minstret_q;
        trap_pc_d  = trap_pc_q;

        take_trap  = (state_q == IDLE) && io_is_except;
        do_write   = (state_q == IDLE) && io_csr_is_w && !io_is_except;

        case (state_q)
            IDLE: begin
                if (take_trap) begin
                    state_d   = TRAP;
                    mepc_d    = {io_pc[XLEN-1:1], 1'b0};
                    mcause_d  = {{(XLEN-6){1'b0}}, io_exception};
                    mpie_d    = mie_q;
                    mie_d     = 1'b0;
                    trap_pc_d = mtvec_q;
                end else if (io_valid) begin
                    minstret_d = minstret_q + XLEN'(1);
                end
            end
            TRAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_write) begin
            case (io_csr_waddr)
                A_MSTATUS: begin
                    mie_d  = io_csr_wdata[3];
                    mpie_d = io_csr_wdata[7];
                end
                A_MTVEC:    mtvec_d    = {io_csr_wdata[XLEN-1:2], 2'b00};
                A_MSCRATCH: mscratch_d = io_csr_wdata;
                A_MEPC:     mepc_d     = {io_csr_wdata[XLEN-1:1], 1'b0};
                A_MCAUSE:   mcause_d   = io_csr_wdata;
                A_MCYCLE:   mcycle_d   = io_csr_wdata;
                A_MINSTRET: minstret_d = io_csr_wdata;
                default: ;
            endcase
        end
    end

    // State register with asynchronous active-low clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
            trap_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            trap_pc_q  <= trap_pc_d;
        end
    end

    // Redirect pulse is the registered TRAP state, so reset drops it at once.
    always_comb begin
        io_trap_valid = (state_q == TRAP);
        io_busy       = (state_q == TRAP);
        io_trap_pc    = trap_pc_q;
        io_mepc       = mepc_q;
        io_mstatus    = mstatus_rd;
    end

endmodule
